// File: rtl/counter_hex_display_n_pkg.sv
// Shared constants for the N-digit hex/BCD counter: digit width and the
// active-low seven-segment glyph table (bit 6 = g ... bit 0 = a).
package counter_hex_display_n_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [SEG_W-1:0]   seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/counter_hex_display_n_hex_seg_decoder.sv
// One digit of seven-segment decode; blank_i overrides the glyph with all
// segments off.
module hex_seg_decoder
  import counter_hex_display_n_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  input  logic               blank_i,
  output logic [SEG_W-1:0]   seg_o
);

  always_comb begin
    seg_o = SEG_TABLE[digit_i];
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end
  end

endmodule

// File: rtl/counter_hex_display_n.sv
// N-digit up/down counter (hex or BCD digits) with synchronous load, a
// registered wrap pulse and a combinational seven-segment display of Q.
module counter_hex_display_n
  import counter_hex_display_n_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned BCD      = 0,
  parameter int unsigned BLANK_LZ = 0
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        En,
  input  logic                        Up,
  input  logic                        Load,
  input  logic [DIGIT_W*DIGITS-1:0]   D,
  output logic [DIGIT_W*DIGITS-1:0]   Q,
  output logic                        Wrap,
  output logic [SEG_W*DIGITS-1:0]     HEX
);

  localparam digit_t DIGIT_MAX = (BCD != 0) ? 4'd9 : 4'hF;

  logic [DIGIT_W*DIGITS-1:0] q_q, q_d;
  logic [DIGIT_W*DIGITS-1:0] step_val;
  logic [DIGIT_W*DIGITS-1:0] load_val;
  logic                      wrap_q, wrap_d;

  // Each digit steps only when every lower digit rolled over; the carry out
  // of the top digit is exactly the whole-counter wrap condition.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    digit_t cur, ld, nxt;
    logic   cin, cout, lz;

    assign cur = q_q[DIGIT_W*k +: DIGIT_W];
    assign ld  = D[DIGIT_W*k +: DIGIT_W];

    if (k == 0) begin : g_lsd
      assign cin = 1'b1;
    end else begin : g_chain
      assign cin = g_digit[k-1].cout;
    end

    always_comb begin
      nxt  = cur;
      cout = 1'b0;
      if (cin) begin
        if (Up) begin
          if (cur >= DIGIT_MAX) begin
            nxt  = '0;
            cout = 1'b1;
          end else begin
            nxt = cur + 4'd1;
          end
        end else begin
          if (cur == '0) begin
            nxt  = DIGIT_MAX;
            cout = 1'b1;
          end else begin
            nxt = cur - 4'd1;
          end
        end
      end
    end

    assign step_val[DIGIT_W*k +: DIGIT_W] = nxt;
    assign load_val[DIGIT_W*k +: DIGIT_W] =
      ((BCD != 0) && (ld > 4'd9)) ? 4'd9 : ld;

    // lz: this digit and every digit above it are zero.
    if (k == DIGITS - 1) begin : g_top
      assign lz = (cur == '0);
    end else begin : g_below
      assign lz = (cur == '0) && g_digit[k+1].lz;
    end

    hex_seg_decoder u_seg (
      .digit_i (cur),
      .blank_i ((BLANK_LZ != 0) && (k != 0) && lz),
      .seg_o   (HEX[SEG_W*k +: SEG_W])
    );
  end

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (Load) begin
      q_d = load_val;
    end else if (En) begin
      q_d    = step_val;
      wrap_d = g_digit[DIGITS-1].cout;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign Wrap = wrap_q;

endmodule

// File: tb/tb_counter_hex_display_n.sv
// Self-checking bench: four counter elaborations driven in lockstep and
// compared against an integer-valued reference model.
module tb_counter_hex_display_n;

  logic        Clock = 1'b0;
  logic        Reset, Load, En, Up;
  logic [31:0] d8;
  logic [15:0] d4;
  logic [3:0]  d1;

  logic [15:0] q4h, q4b;
  logic [3:0]  q1;
  logic [31:0] q8;
  logic        w4h, w4b, w1, w8;
  logic [27:0] hex4h, hex4b;
  logic [6:0]  hex1;
  logic [55:0] hex8;

  always #5 Clock = ~Clock;

  // idx 0: 4 hex digits, 1: 4 BCD digits blanked, 2: 1 BCD digit, 3: 8 hex digits blanked
  counter_hex_display_n #(.DIGITS(4), .BCD(0), .BLANK_LZ(0)) u_hex4 (
    .Clock(Clock), .Reset(Reset), .En(En), .Up(Up), .Load(Load),
    .D(d4), .Q(q4h), .Wrap(w4h), .HEX(hex4h));
  counter_hex_display_n #(.DIGITS(4), .BCD(1), .BLANK_LZ(1)) u_bcd4 (
    .Clock(Clock), .Reset(Reset), .En(En), .Up(Up), .Load(Load),
    .D(d4), .Q(q4b), .Wrap(w4b), .HEX(hex4b));
  counter_hex_display_n #(.DIGITS(1), .BCD(1), .BLANK_LZ(0)) u_bcd1 (
    .Clock(Clock), .Reset(Reset), .En(En), .Up(Up), .Load(Load),
    .D(d1), .Q(q1), .Wrap(w1), .HEX(hex1));
  counter_hex_display_n #(.DIGITS(8), .BCD(0), .BLANK_LZ(1)) u_hex8 (
    .Clock(Clock), .Reset(Reset), .En(En), .Up(Up), .Load(Load),
    .D(d8), .Q(q8), .Wrap(w8), .HEX(hex8));

  localparam int NI = 4;
  localparam int NDIG [NI] = '{4, 4, 1, 8};
  localparam bit ISBCD[NI] = '{1'b0, 1'b1, 1'b1, 1'b0};
  localparam bit ISBL [NI] = '{1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [6:0] OFF = 7'h7F;

  longint      mv [NI];
  bit          mw [NI];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  function automatic longint base_of(input bit bcd);
    return bcd ? 64'd10 : 64'd16;
  endfunction

  function automatic longint max_of(input int n, input bit bcd);
    longint m = 1;
    for (int i = 0; i < n; i++) m = m * base_of(bcd);
    return m - 1;
  endfunction

  function automatic longint load_num(input logic [31:0] d, input int n, input bit bcd);
    longint v = 0;
    longint dig;
    for (int i = n - 1; i >= 0; i--) begin
      dig = longint'(d[4*i +: 4]);
      if (bcd && dig > 9) dig = 9;
      v = v * base_of(bcd) + dig;
    end
    return v;
  endfunction

  function automatic logic [31:0] enc(input longint v, input int n, input bit bcd);
    logic [31:0] q = '0;
    longint r = v;
    for (int i = 0; i < n; i++) begin
      q[4*i +: 4] = 4'(r % base_of(bcd));
      r = r / base_of(bcd);
    end
    return q;
  endfunction

  function automatic logic [55:0] exp_hex(input logic [31:0] q, input int n, input bit bl);
    logic [55:0] h = '0;
    int msd = 0;
    for (int i = 0; i < n; i++) if (q[4*i +: 4] != 4'h0) msd = i;
    for (int i = 0; i < n; i++)
      h[7*i +: 7] = (bl && i > msd) ? OFF : GLYPH[q[4*i +: 4]];
    return h;
  endfunction

  task automatic model_step(input int i);
    longint mx;
    mx = max_of(NDIG[i], ISBCD[i]);
    mw[i] = 1'b0;
    if (Reset) mv[i] = 0;
    else if (Load) mv[i] = load_num(d8, NDIG[i], ISBCD[i]);
    else if (En) begin
      if (Up) begin
        if (mv[i] == mx) begin mv[i] = 0; mw[i] = 1'b1; end
        else mv[i] = mv[i] + 1;
      end else begin
        if (mv[i] == 0) begin mv[i] = mx; mw[i] = 1'b1; end
        else mv[i] = mv[i] - 1;
      end
    end
  endtask

  task automatic drive(input bit rst, input bit ld, input bit en, input bit up, input logic [31:0] d);
    Reset = rst; Load = ld; En = en; Up = up;
    d8 = d; d4 = d[15:0]; d1 = d[3:0];
  endtask

  task automatic tick();
    @(posedge Clock);
    for (int i = 0; i < NI; i++) model_step(i);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 1, 32'h1234_5678);
    tick();
    n_cmp++; if (q4h !== 16'h0 || w4h !== 1'b0) begin n_bad++;
      $display("FAIL reset_hex4 got Q=%h W=%b exp Q=0000 W=0", q4h, w4h); end
    n_cmp++; if (q4b !== 16'h0 || w4b !== 1'b0 || q1 !== 4'h0 || q8 !== 32'h0) begin n_bad++;
      $display("FAIL reset_others got %h %h %h W=%b", q4b, q1, q8, w4b); end
    n_cmp++; if (hex4h !== {4{7'h40}}) begin n_bad++;
      $display("FAIL reset_hex4_seg got %h exp %h", hex4h, {4{7'h40}}); end
    n_cmp++; if (hex4b !== {OFF, OFF, OFF, 7'h40}) begin n_bad++;
      $display("FAIL reset_bcd4_blank got %h exp %h", hex4b, {OFF, OFF, OFF, 7'h40}); end
    n_cmp++; if (hex8 !== {{7{OFF}}, 7'h40}) begin n_bad++;
      $display("FAIL reset_hex8_blank got %h", hex8); end
  endtask

  task automatic test_full_wrap_hex();
    int wraps = 0;
    drive(1, 0, 0, 0, 32'h0);
    tick();
    drive(0, 0, 1, 1, 32'h0);
    for (int e = 0; e < 65536; e++) begin
      tick();
      if (w4h === 1'b1) wraps++;
      n_cmp++; if (w4h !== (e == 65535)) begin n_bad++;
        $display("FAIL full_wrap_pulse edge=%0d got W=%b Q=%h", e, w4h, q4h); end
    end
    n_cmp++; if (q4h !== 16'h0 || wraps != 1) begin n_bad++;
      $display("FAIL full_wrap_end got Q=%h wraps=%0d exp Q=0000 wraps=1", q4h, wraps); end
    drive(0, 0, 0, 1, 32'h0);
    tick();
    n_cmp++; if (w4h !== 1'b0) begin n_bad++;
      $display("FAIL full_wrap_one_cycle got W=%b exp 0", w4h); end
  endtask

  task automatic test_bcd_carry();
    drive(0, 1, 0, 0, 32'h0999);
    tick();
    drive(0, 0, 1, 1, 32'h0);
    tick();
    n_cmp++; if (q4b !== 16'h1000 || w4b !== 1'b0) begin n_bad++;
      $display("FAIL bcd_carry got Q=%h W=%b exp Q=1000 W=0", q4b, w4b); end
    n_cmp++; if (q4h !== 16'h099A) begin n_bad++;
      $display("FAIL hex_inc got Q=%h exp 099a", q4h); end
    drive(0, 1, 0, 0, 32'h9999);
    tick();
    drive(0, 0, 1, 1, 32'h0);
    tick();
    n_cmp++; if (q4b !== 16'h0000 || w4b !== 1'b1) begin n_bad++;
      $display("FAIL bcd_wrap_up got Q=%h W=%b exp Q=0000 W=1", q4b, w4b); end
  endtask

  task automatic test_bcd_clamp_down();
    drive(0, 1, 1, 1, 32'h00AF);
    tick();
    n_cmp++; if (q4b !== 16'h0099 || q4h !== 16'h00AF || w4b !== 1'b0) begin n_bad++;
      $display("FAIL load_clamp got bcd=%h hex=%h exp bcd=0099 hex=00af", q4b, q4h); end
    drive(0, 1, 0, 0, 32'h0);
    tick();
    drive(0, 0, 1, 0, 32'h0);
    tick();
    n_cmp++; if (q4b !== 16'h9999 || w4b !== 1'b1) begin n_bad++;
      $display("FAIL bcd_wrap_down got Q=%h W=%b exp Q=9999 W=1", q4b, w4b); end
    n_cmp++; if (q4h !== 16'hFFFF || w4h !== 1'b1) begin n_bad++;
      $display("FAIL hex_wrap_down got Q=%h W=%b exp Q=ffff W=1", q4h, w4h); end
    drive(0, 0, 0, 0, 32'h0);
    tick();
    n_cmp++; if (w4b !== 1'b0 || q4b !== 16'h9999) begin n_bad++;
      $display("FAIL hold_after_wrap got Q=%h W=%b exp Q=9999 W=0", q4b, w4b); end
  endtask

  task automatic test_priority();
    drive(1, 1, 1, 1, 32'h1234);
    tick();
    n_cmp++; if (q4h !== 16'h0 || w4h !== 1'b0) begin n_bad++;
      $display("FAIL prio_reset got Q=%h W=%b exp 0000/0", q4h, w4h); end
    drive(0, 1, 1, 1, 32'h1234);
    tick();
    n_cmp++; if (q4h !== 16'h1234 || q4b !== 16'h1234) begin n_bad++;
      $display("FAIL prio_load got hex=%h bcd=%h exp 1234", q4h, q4b); end
    drive(0, 1, 0, 0, 32'hFFFF);
    tick();
    drive(0, 1, 1, 1, 32'hFFFF);
    tick();
    n_cmp++; if (q4h !== 16'hFFFF || w4h !== 1'b0 || w4b !== 1'b0) begin n_bad++;
      $display("FAIL load_max_no_wrap got Q=%h W=%b/%b exp ffff 0/0", q4h, w4h, w4b); end
    drive(1, 0, 1, 1, 32'h0);
    tick();
    n_cmp++; if (q4h !== 16'h0 || w4h !== 1'b0) begin n_bad++;
      $display("FAIL reset_midcount got Q=%h W=%b exp 0000/0", q4h, w4h); end
  endtask

  task automatic test_blank();
    drive(0, 1, 0, 0, 32'h0050);
    tick();
    n_cmp++; if (hex4b !== {OFF, OFF, 7'h12, 7'h40}) begin n_bad++;
      $display("FAIL blank_0050 got %h exp %h", hex4b, {OFF, OFF, 7'h12, 7'h40}); end
    n_cmp++; if (hex4h !== {7'h40, 7'h40, 7'h12, 7'h40}) begin n_bad++;
      $display("FAIL noblank_0050 got %h", hex4h); end
    drive(0, 1, 0, 0, 32'h0);
    tick();
    n_cmp++; if (hex4b !== {OFF, OFF, OFF, 7'h40}) begin n_bad++;
      $display("FAIL blank_zero got %h", hex4b); end
  endtask

  task automatic test_widths();
    drive(0, 1, 0, 0, 32'hFFFF_FFFF);
    tick();
    n_cmp++; if (q1 !== 4'h9 || q8 !== 32'hFFFF_FFFF) begin n_bad++;
      $display("FAIL width_load got d1=%h d8=%h exp 9 ffffffff", q1, q8); end
    drive(0, 0, 1, 1, 32'h0);
    tick();
    n_cmp++; if (q1 !== 4'h0 || w1 !== 1'b1 || hex1 !== 7'h40) begin n_bad++;
      $display("FAIL d1_wrap got Q=%h W=%b H=%h exp 0 1 40", q1, w1, hex1); end
    n_cmp++; if (q8 !== 32'h0 || w8 !== 1'b1 || hex8 !== {{7{OFF}}, 7'h40}) begin n_bad++;
      $display("FAIL d8_wrap got Q=%h W=%b H=%h", q8, w8, hex8); end
  endtask

  task automatic test_random();
    logic [31:0] act_q [NI];
    logic [31:0] exp_q [NI];
    logic [55:0] act_h [NI];
    logic [55:0] exp_h [NI];
    logic        act_w [NI];
    logic [31:0] d;
    int          sel;
    for (int c = 0; c < 3000; c++) begin
      sel = int'($urandom_range(0, 3));
      d = (sel == 0) ? 32'hFFFF_FFFF : (sel == 1) ? 32'h0 : $urandom;
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 8,
            $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 50, d);
      tick();
      act_q[0] = {16'h0, q4h};  act_q[1] = {16'h0, q4b};
      act_q[2] = {28'h0, q1};   act_q[3] = q8;
      act_h[0] = {28'h0, hex4h}; act_h[1] = {28'h0, hex4b};
      act_h[2] = {49'h0, hex1};  act_h[3] = hex8;
      act_w[0] = w4h; act_w[1] = w4b; act_w[2] = w1; act_w[3] = w8;
      for (int i = 0; i < NI; i++) begin
        exp_q[i] = enc(mv[i], NDIG[i], ISBCD[i]);
        exp_h[i] = exp_hex(exp_q[i], NDIG[i], ISBL[i]);
        n_cmp++; if (act_q[i] !== exp_q[i]) begin n_bad++;
          $display("FAIL rnd_q inst=%0d cyc=%0d got=%h exp=%h", i, c, act_q[i], exp_q[i]); end
        n_cmp++; if (act_w[i] !== mw[i]) begin n_bad++;
          $display("FAIL rnd_wrap inst=%0d cyc=%0d got=%b exp=%b", i, c, act_w[i], mw[i]); end
        n_cmp++; if (act_h[i] !== exp_h[i]) begin n_bad++;
          $display("FAIL rnd_hex inst=%0d cyc=%0d got=%h exp=%h", i, c, act_h[i], exp_h[i]); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin mv[i] = 0; mw[i] = 1'b0; end
    drive(1, 0, 0, 0, 32'h0);
    test_reset();
    test_full_wrap_hex();
    test_bcd_carry();
    test_bcd_clamp_down();
    test_priority();
    test_blank();
    test_widths();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
